// File: rtl/next_b_fifo_pkg.sv
// Shared sizing helpers for the next_b result FIFO.
// Every width is derived from the block parameters through these functions.
package next_b_fifo_pkg;

    localparam int DEF_BYTE  = 8;
    localparam int DEF_WORDS = 12;
    localparam int DEF_DEPTH = 4;

    function automatic int word_w(input int byte_bits, input int words);
        return byte_bits * words;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/next_b_mem.sv
// Result word storage: DEPTH x W register array, one write port, one async read port.
// Storage is not reset; the control logic in the top masks stale entries via count.
module next_b_mem #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/next_b_fifo.sv
// Result FIFO between the hashing core and the consumer: captures words on finished,
// presents them show-ahead with valid/ready, and replays the last word (or zero) when empty.
module next_b_fifo
    import next_b_fifo_pkg::*;
#(
    parameter int BYTE         = DEF_BYTE,
    parameter int WORDS        = DEF_WORDS,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int HOLD_LAST    = 1,
    parameter int CAPTURE_EDGE = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic [word_w(BYTE, WORDS)-1:0]      data_in,
    input  logic                                finished,
    input  logic                                out_ready,
    output logic [word_w(BYTE, WORDS)-1:0]      next_out,
    output logic                                out_valid,
    output logic                                full,
    output logic                                empty,
    output logic [cnt_w(DEPTH)-1:0]             count,
    output logic                                overflow
);

    localparam int W     = word_w(BYTE, WORDS);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q;
    logic             finished_q;
    logic [W-1:0]     last_q;
    logic [W-1:0]     head;
    logic             cap, push, pop, drop;

    // Status flags come from count alone so full and empty can never disagree.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign cap  = (CAPTURE_EDGE != 0) ? (finished & ~finished_q) : finished;
    assign pop  = out_valid & out_ready;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    next_b_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign next_out = ~empty ? head : ((HOLD_LAST != 0) ? last_q : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            finished_q <= 1'b0;
            last_q     <= '0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            finished_q <= 1'b0;
            last_q     <= '0;
        end else begin
            finished_q <= finished;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= head;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_next_b_fifo.sv
// Self-checking bench for next_b_fifo: directed scenarios plus random traffic against a queue model,
// and a second instance (HOLD_LAST=0, CAPTURE_EDGE=1) checked with directed constants.
module tb_next_b_fifo;

    localparam int W     = 96;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear, finished, out_ready;
    logic [W-1:0]  data_in, next_out;
    logic          out_valid, full, empty, overflow;
    logic [2:0]    count;

    logic          clear_e, fin_e, rdy_e;
    logic [W-1:0]  data_e, next_out_e;
    logic          out_valid_e, full_e, empty_e, overflow_e;
    logic [2:0]    count_e;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] mq [$];
    logic [W-1:0] m_last;
    logic         m_ovf;

    always #5 clk = ~clk;

    next_b_fifo dut (
        .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .finished(finished),
        .out_ready(out_ready), .next_out(next_out), .out_valid(out_valid), .full(full),
        .empty(empty), .count(count), .overflow(overflow)
    );

    next_b_fifo #(.HOLD_LAST(0), .CAPTURE_EDGE(1)) dut_e (
        .clk(clk), .reset(reset), .clear(clear_e), .data_in(data_e), .finished(fin_e),
        .out_ready(rdy_e), .next_out(next_out_e), .out_valid(out_valid_e), .full(full_e),
        .empty(empty_e), .count(count_e), .overflow(overflow_e)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    // Reference: a plain queue; pop takes the front, push appends, a capture into a full
    // queue with no pop is lost and flags overflow.
    task automatic model_edge(input logic f, input logic [W-1:0] d, input logic r, input logic c);
        bit was_full, do_pop;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && r;
        if (c) begin
            model_reset();
        end else begin
            if (do_pop) m_last = mq.pop_front();
            if (f && (!was_full || do_pop)) mq.push_back(d);
            else if (f) m_ovf = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] exp_out;
        exp_out = (mq.size() != 0) ? mq[0] : m_last;
        chk({tag, ".next_out"},  next_out, exp_out);
        chk({tag, ".count"},     W'(count), W'(mq.size()));
        chk({tag, ".out_valid"}, W'(out_valid), W'(mq.size() != 0));
        chk({tag, ".full"},      W'(full), W'(mq.size() == DEPTH));
        chk({tag, ".empty"},     W'(empty), W'(mq.size() == 0));
        chk({tag, ".overflow"},  W'(overflow), W'(m_ovf));
    endtask

    task automatic step(input string tag, input logic f, input logic [W-1:0] d,
                        input logic r, input logic c);
        finished  = f;
        data_in   = d;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        model_edge(f, d, r, c);
        #1;
        check_model(tag);
    endtask

    task automatic step_e(input logic f, input logic [W-1:0] d, input logic r);
        fin_e  = f;
        data_e = d;
        rdy_e  = r;
        step("idle", 1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b0; clear = 1'b0; finished = 1'b0; out_ready = 1'b0; data_in = '0;
        clear_e = 1'b0; fin_e = 1'b0; rdy_e = 1'b0; data_e = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("rst_init");
        chk("rst_init_e.empty", W'(empty_e), W'(1));
        @(negedge clk);
        reset = 1'b1;
        step("post_rst", 1'b0, '0, 1'b0, 1'b0);

        // Order with out_ready high, then hold of the last word
        step("ord1", 1'b1, 96'hA1, 1'b1, 1'b0);
        step("ord2", 1'b1, 96'hA2, 1'b1, 1'b0);
        step("ord3", 1'b1, 96'hA3, 1'b1, 1'b0);
        step("ord4", 1'b0, 96'h0,  1'b1, 1'b0);
        chk("ord_hold", next_out, 96'hA3);
        chk("ord_empty", W'(empty), W'(1));

        // Five captures into DEPTH=4 with the consumer stalled
        for (int i = 0; i < 5; i++) step("fill", 1'b1, W'(96'h11 + i), 1'b0, 1'b0);
        chk("ovf_count", W'(count), W'(4));
        chk("ovf_flag", W'(overflow), W'(1));
        chk("ovf_head", next_out, 96'h11);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        chk("ovf_last", next_out, 96'h14);
        chk("ovf_sticky", W'(overflow), W'(1));

        // Clear beats a simultaneous capture and pop; then wrap the pointers
        step("pre_clr", 1'b1, 96'hC1, 1'b0, 1'b0);
        step("pre_clr", 1'b1, 96'hC2, 1'b0, 1'b0);
        step("clr", 1'b1, 96'hC3, 1'b1, 1'b1);
        chk("clr_empty", W'(empty), W'(1));
        chk("clr_ovf", W'(overflow), W'(0));
        chk("clr_out", next_out, '0);
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1'b1, rand_word(), 1'b1, 1'b0);
            chk("wrap_cnt_le1", W'(count <= 3'd1), W'(1));
        end
        step("wrap_end", 1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous capture and pop
        for (int i = 0; i < 4; i++) step("fill4", 1'b1, W'(96'h41 + i), 1'b0, 1'b0);
        step("fullpp", 1'b1, 96'h55, 1'b1, 1'b0);
        chk("fullpp_cnt", W'(count), W'(4));
        chk("fullpp_ovf", W'(overflow), W'(0));
        for (int i = 0; i < 3; i++) step("fullpp_drain", 1'b0, '0, 1'b1, 1'b0);
        chk("fullpp_tail", next_out, 96'h55);
        step("fullpp_last", 1'b0, '0, 1'b1, 1'b0);

        // Edge-capture / zero-when-empty instance
        step_e(1'b1, 96'hE1, 1'b0);
        for (int i = 0; i < 4; i++) step_e(1'b1, 96'hEE, 1'b0);
        chk("edge_hold_cnt", W'(count_e), W'(1));
        step_e(1'b0, 96'hEE, 1'b0);
        step_e(1'b1, 96'hE2, 1'b0);
        step_e(1'b0, 96'hEE, 1'b0);
        step_e(1'b1, 96'hE3, 1'b0);
        chk("edge_101_cnt", W'(count_e), W'(3));
        step_e(1'b0, 96'hEE, 1'b0);
        chk("edge_pop1", next_out_e, 96'hE1);
        step_e(1'b0, '0, 1'b1);
        chk("edge_pop2", next_out_e, 96'hE2);
        step_e(1'b0, '0, 1'b1);
        chk("edge_pop3", next_out_e, 96'hE3);
        step_e(1'b0, '0, 1'b1);
        chk("edge_zero_out", next_out_e, '0);
        chk("edge_empty", W'(empty_e), W'(1));
        rdy_e = 1'b0;

        // Random traffic: a stall-heavy phase then a drain-heavy phase
        for (int i = 0; i < 400; i++) begin
            logic f, r, c;
            f = ($urandom_range(0, 99) < 60);
            r = (i < 200) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 63) == 0);
            step("rand", f, rand_word(), r, c);
        end

        // Asynchronous reset mid-stream with three words queued
        step("rst_mid0", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, W'(96'h71 + i), 1'b0, 1'b0);
        fin_e = 1'b1; data_e = 96'hE9;
        step("rst_fill_e", 1'b0, '0, 1'b0, 1'b0);
        chk("rst_mid_cnt_pre", W'(count), W'(3));
        finished = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_async.count", W'(count), W'(0));
        chk("rst_async.empty", W'(empty), W'(1));
        chk("rst_async.next_out", next_out, '0);
        chk("rst_async.overflow", W'(overflow), W'(0));
        chk("rst_async_e.count", W'(count_e), W'(0));
        fin_e = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step("rst_release", 1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
